config_loader: RTL
==================

Name: config_loader

Overview:
- Sequences the configuration shift chain of a logic tile, or of several tiles daisy-chained config_out to config_in.
- Accepts the bitstream as words over a valid/ready stream and serializes it LSB-first onto the chain.
- Can optionally loop the chain back on itself to CRC-check the loaded contents without destroying them.
- Holds the fabric in reset until loading completes cleanly.

Parameters:
- WORD_WIDTH, 32, width of incoming bitstream words.
- CHAIN_BITS, 524, total length of the config shift chain in bits (524 per tile times the number of tiles).
- CLEAR_CYCLES, 4, number of cycles config_nreset is held low before loading.

Ports:
- clock  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load; ignored while busy.
- verify_en  in  1  sampled with start; 1 = run the readback verify pass after load.
- s_data  in  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts s_data this cycle.
- config_in  out  1  serial data to the chain head.
- config_enable  out  1  chain shift enable.
- config_nreset  out  1  chain clear, active low.
- config_out  in  1  chain tail bit.
- fabric_nreset  out  1  user-logic reset to the tiles, active low.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse on return to IDLE after a load.
- error  out  1  verify CRC mismatch; sticky until the next accepted start.
- crc_out  out  16  CRC of the bits shifted in during LOAD.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE; s_ready=0; config_in=0; config_enable=0.
  - config_nreset=1; fabric_nreset=0; busy=0; done=0; error=0.
  - crc_out=16'hFFFF; all counters 0.
- Derived constant: NWORDS = ceil(CHAIN_BITS/WORD_WIDTH), which is 17 at the default parameters.
- States: IDLE, CLEAR, LOAD, VERIFY, FINISH.
- IDLE:
  - On start=1, latch verify_en, clear error, initialize both CRCs to 16'hFFFF, assert fabric_nreset=0, and go to CLEAR.
- CLEAR:
  - config_nreset=0 for exactly CLEAR_CYCLES cycles, then go to LOAD.
- LOAD word buffer:
  - A word register with a remaining-bit count.
  - s_ready=1 only when the buffer is empty and fewer than NWORDS words have been accepted.
  - A word is accepted on s_valid && s_ready.
  - The last word loads only CHAIN_BITS - (NWORDS-1)*WORD_WIDTH bits; its upper bits are discarded (12 bits at the defaults).
- LOAD shifting:
  - Each cycle the buffer is non-empty: config_enable=1, config_in=buffer bit 0, buffer shifts right, bit counter increments, and crc_in is updated with that bit.
  - When the buffer is empty: config_enable=0 (stall). Upstream stalls of any length are legal.
  - When the bit counter reaches CHAIN_BITS, go to VERIFY if verify_en was latched, else FINISH.
- CRC: CRC-16-CCITT, bit-serial, polynomial 0x1021, init 0xFFFF.
  - fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - crc_out is updated live.
- VERIFY:
  - Lasts exactly CHAIN_BITS cycles, with config_enable=1 and config_in=config_out (loopback).
  - Each cycle, config_out is sampled before the shift takes effect and folded into crc_rb.
  - The chain ends with its contents unchanged.
  - At the end: error = (crc_rb != crc_out). Go to FINISH.
- FINISH:
  - One cycle with done=1.
  - fabric_nreset=1 if error==0, else it stays 0.
  - Go to IDLE.
- Outside LOAD and VERIFY, config_enable=0 and config_in=0.
- start while busy=1 is ignored.
- s_valid is ignored outside LOAD; no word is consumed.
- Async reset mid-operation: return to reset values immediately. Chain contents are undefined afterwards; a new start is required.
- fabric_nreset keeps its last value in IDLE; it goes low only on start or reset.

Test Plan:
- Default params; start with verify_en=0; stream 17 words back-to-back, word i = 32'hA5A50000|i.
  - config_nreset is low for exactly 4 cycles.
  - config_enable is high for exactly 524 cycles in total.
  - Chain model contents match the bitstream.
  - done pulses once; fabric_nreset=1.
- Same stream with verify_en=1 and a correct chain model.
  - A VERIFY of 524 cycles follows LOAD.
  - Chain contents are unchanged afterwards.
  - error=0; fabric_nreset=1; crc_out equals the reference-model CRC.
- verify_en=1 with the chain model flipping one bit at position 300.
  - error=1; fabric_nreset stays 0; done pulses.
  - The next start clears error.
- Random s_valid gaps of 0-7 cycles.
  - config_enable is low during every gap.
  - Total of 524 shifted bits.
  - Final word: only bits 11:0 appear on config_in.
- Pulse start while busy, and drive s_valid in IDLE.
  - No effect; s_ready stays 0.
- Assert nreset low mid-LOAD at bit 200.
  - All outputs take their reset values asynchronously.
  - A subsequent start performs a full clean load.

Source files
------------

// File: rtl/config_loader.sv
// config_loader: takes a bitstream as words on a valid/ready stream and
// shifts it LSB-first into a tile configuration chain. An optional loopback
// pass re-reads the chain through a second CRC without disturbing it. The
// fabric is held in reset until a load finishes cleanly.
module config_loader #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_BITS   = 524,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  config_in,
    output logic                  config_enable,
    output logic                  config_nreset,
    input  logic                  config_out,
    output logic                  fabric_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           crc_out
);

    localparam int NWORDS    = (CHAIN_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    // The final word only carries the bits that are left over.
    localparam int LAST_BITS = CHAIN_BITS - (NWORDS - 1) * WORD_WIDTH;

    localparam int BCW = $clog2(CHAIN_BITS + 1);
    localparam int WCW = $clog2(NWORDS + 1);
    localparam int SCW = $clog2(WORD_WIDTH + 1);
    localparam int CCW = $clog2(CLEAR_CYCLES + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAIN_BITS - 1);
    localparam logic [WCW-1:0] WORD_MAX  = WCW'(NWORDS);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);
    localparam logic [SCW-1:0] FULL_CNT  = SCW'(WORD_WIDTH);
    localparam logic [SCW-1:0] TAIL_CNT  = SCW'(LAST_BITS);
    localparam logic [CCW-1:0] CLR_LAST  = CCW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        VERIFY,
        FINISH
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] word_buf;
    logic [SCW-1:0]        buf_cnt;    // bits still waiting in word_buf
    logic [WCW-1:0]        word_cnt;   // words accepted this load
    logic [BCW-1:0]        bit_cnt;    // chain bits shifted (LOAD) or read back (VERIFY)
    logic [CCW-1:0]        clr_cnt;
    logic                  verify_latched;
    logic [15:0]           crc_in;
    logic [15:0]           crc_rb;
    logic                  shifting;

    // CRC-16-CCITT, one bit per step, MSB-first feedback
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign busy     = (state != IDLE);
    assign s_ready  = (state == LOAD) && (buf_cnt == '0) && (word_cnt < WORD_MAX);
    assign shifting = (state == LOAD) && (buf_cnt != '0);
    assign crc_out  = crc_in;

    // Chain drive: buffer LSB while loading, tail looped to head while verifying.
    // The loopback must be combinational so the ring length stays CHAIN_BITS.
    always_comb begin
        config_enable = 1'b0;
        config_in     = 1'b0;
        if (shifting) begin
            config_enable = 1'b1;
            config_in     = word_buf[0];
        end else if (state == VERIFY) begin
            config_enable = 1'b1;
            config_in     = config_out;
        end
    end

    // Sequencer: clear, load, optional verify, then release the fabric
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state          <= IDLE;
            word_buf       <= '0;
            buf_cnt        <= '0;
            word_cnt       <= '0;
            bit_cnt        <= '0;
            clr_cnt        <= '0;
            verify_latched <= 1'b0;
            crc_in         <= 16'hFFFF;
            crc_rb         <= 16'hFFFF;
            config_nreset  <= 1'b1;
            fabric_nreset  <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        verify_latched <= verify_en;
                        error          <= 1'b0;
                        crc_in         <= 16'hFFFF;
                        crc_rb         <= 16'hFFFF;
                        fabric_nreset  <= 1'b0;
                        config_nreset  <= 1'b0;
                        clr_cnt        <= '0;
                        word_cnt       <= '0;
                        bit_cnt        <= '0;
                        buf_cnt        <= '0;
                        state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        config_nreset <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (buf_cnt != '0) begin
                        word_buf <= word_buf >> 1;
                        buf_cnt  <= buf_cnt - 1'b1;
                        crc_in   <= crc_step(crc_in, word_buf[0]);
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= verify_latched ? VERIFY : FINISH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (s_valid && s_ready) begin
                        // Upper bits of the final word are never shifted out.
                        word_buf <= s_data;
                        buf_cnt  <= (word_cnt == WORD_LAST) ? TAIL_CNT : FULL_CNT;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                VERIFY: begin
                    crc_rb <= crc_step(crc_rb, config_out);
                    if (bit_cnt == BIT_LAST) begin
                        error   <= (crc_step(crc_rb, config_out) != crc_in);
                        bit_cnt <= '0;
                        state   <= FINISH;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    done          <= 1'b1;
                    fabric_nreset <= !error;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
